// File: rtl/gpio_port.sv
// gpio_port: bank of WIDHT bidirectional GPIO pins on the simple peripheral bus.
// Build option GPIO_SYNC_EN routes pin levels through a two-flop synchronizer.
module gpio_port #(
    parameter int WIDHT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    inout  wire  [WIDHT-1:0] gpio
);

    logic [WIDHT-1:0] dir;
    logic [WIDHT-1:0] out;
    logic [WIDHT-1:0] pin_in;
    logic [31:0]      rd_next;
    logic             unused_bits;

    // Writes are not address-decoded; only the selector and payload matter.
    assign unused_bits = ^{address[31:4], address[1:0], write_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir <= '1;
            out <= '0;
        end else if (write) begin
            if (write_data[31])
                out <= write_data[WIDHT-1:0];
            else
                dir <= write_data[WIDHT-1:0];
        end
    end

    for (genvar i = 0; i < WIDHT; i++) begin : g_pad
        assign gpio[i] = dir[i] ? 1'bz : out[i];
    end

`ifdef GPIO_SYNC_EN
    logic [WIDHT-1:0] sync_q1;
    logic [WIDHT-1:0] sync_q2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= gpio;
            sync_q2 <= sync_q1;
        end
    end

    assign pin_in = sync_q2;
`else
    assign pin_in = gpio;
`endif

    always_comb begin
        rd_next = '0;
        unique case (address[3:2])
            2'd0: rd_next[WIDHT-1:0] = pin_in;
            2'd1: rd_next[WIDHT-1:0] = dir;
            2'd2: rd_next[WIDHT-1:0] = out;
            2'd3: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            read_data <= '0;
        else if (read)
            read_data <= rd_next;
    end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed bus and pin vectors for gpio_port.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_gpio_port;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    wire  [4:0]  gpio;

    logic [4:0]  ext_en;
    logic [4:0]  ext_val;
    logic [31:0] rd;

    int checks;
    int errors;

    gpio_port #(.WIDHT(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .gpio       (gpio)
    );

    for (genvar i = 0; i < 5; i++) begin : g_ext
        assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] d);
        @(negedge clk);
        write      = 1'b1;
        write_data = d;
        @(negedge clk);
        write      = 1'b0;
        write_data = '0;
        idle(3);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        read    = 1'b1;
        address = a;
        @(negedge clk);
        read    = 1'b0;
        address = '0;
        d       = read_data;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        write_data = '0;
        ext_en     = 5'h1F;
        ext_val    = 5'h0A;

        idle(3);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_pins_float", {27'h0, gpio}, 32'h0A);

        ext_en  = 5'h15;
        ext_val = 5'h00;
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        bus_read(32'h4, rd);
        chk("rst_dir", rd, 32'h1F);
        bus_read(32'h8, rd);
        chk("rst_out", rd, 32'h00);

        bus_write(32'h0000_0015);
        chk("dir_pins", {27'h0, gpio}, 32'h00);
        bus_read(32'h4, rd);
        chk("dir_rd", rd, 32'h15);
        bus_read(32'h0, rd);
        chk("dir_pin_in", rd, 32'h00);

        bus_write(32'h8000_001F);
        chk("out_pins", {27'h0, gpio}, 32'h0A);
        bus_read(32'h8, rd);
        chk("out_rd", rd, 32'h1F);
        bus_read(32'h0, rd);
        chk("out_pin_in", rd, 32'h0A);

        ext_val = 5'h11;
        idle(3);
        chk("in_pins", {27'h0, gpio}, 32'h1B);
        bus_read(32'h0, rd);
        chk("in_pin_in", rd, 32'h1B);

        bus_write(32'h8000_0000);
        chk("clr_pins", {27'h0, gpio}, 32'h11);
        bus_read(32'h0, rd);
        chk("clr_pin_in", rd, 32'h11);
        bus_read(32'h4, rd);
        chk("clr_dir", rd, 32'h15);

        bus_read(32'hC, rd);
        chk("addr3_zero", rd, 32'h0);

        bus_write(32'h0000_0FF5);
        bus_read(32'h4, rd);
        chk("hi_bits_ignored", rd, 32'h15);

        @(negedge clk);
        read       = 1'b1;
        address    = 32'h8;
        write      = 1'b1;
        write_data = 32'h8000_0003;
        @(negedge clk);
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        write_data = '0;
        chk("rw_old_out", read_data, 32'h00);
        idle(3);
        chk("rw_hold", read_data, 32'h00);
        chk("rw_pins", {27'h0, gpio}, 32'h13);
        bus_read(32'h8, rd);
        chk("rw_new_out", rd, 32'h03);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        ext_en  = 5'h1F;
        ext_val = 5'h19;
        #1;
        chk("mid_rst_float", {27'h0, gpio}, 32'h19);
        chk("mid_rst_rdata", read_data, 32'h0);

        @(negedge clk);
        read       = 1'b1;
        write      = 1'b1;
        address    = 32'h4;
        write_data = 32'h0000_0000;
        @(negedge clk);
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        chk("rst_strobe_rd", read_data, 32'h0);
        reset = 1'b1;
        idle(2);
        bus_read(32'h4, rd);
        chk("mid_rst_dir", rd, 32'h1F);
        bus_read(32'h8, rd);
        chk("mid_rst_out", rd, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Memory-mapped bank of WIDHT bidirectional general-purpose I/O pins on the processor's simple read/write peripheral bus.
- Each pin is individually configured as input (high-Z) or output.
- The output level of output pins is software-controlled.
- Pin levels are readable over the bus.

Parameters:
- WIDHT, 5, number of GPIO pins; legal range 1..31, since bit 31 of write_data is the command selector.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- read  input  1  read strobe, sampled on clk rising edge.
- write  input  1  write strobe, sampled on clk rising edge.
- address  input  32  register select for reads; ignored for writes.
- write_data  input  32  bit 31 = command select; bits [WIDHT-1:0] = payload.
- read_data  output  32  registered read result.
- gpio  inout  WIDHT  physical pins.

Behaviour:
- Internal registers:
  - dir[WIDHT-1:0]: 1 = input (pin released to Z), 0 = output.
  - out[WIDHT-1:0]: level driven on output pins.
- Reset (reset low, asynchronous): dir = all ones (every pin input/high-Z), out = 0, read_data = 0, input sampling stages = 0.
- Write, on a rising edge with write=1 (address not decoded; block select is done upstream):
  - write_data[31]=0: dir <= write_data[WIDHT-1:0].
  - write_data[31]=1: out <= write_data[WIDHT-1:0].
  - write_data bits [30:WIDHT] are ignored.
- Pin drive is combinational from the registers: gpio[i] = dir[i] ? Z : out[i].
  - A new level appears on a pin immediately after the write edge, i.e. one cycle of latency from the strobe.
- Input sampling: pin_in[i] = sampled level of gpio[i], for inputs and outputs alike. Output pins therefore read back their driven level.
- Read, on a rising edge with read=1, read_data is loaded by address[3:2]:
  - 0: {zeros, pin_in}.
  - 1: {zeros, dir}.
  - 2: {zeros, out}.
  - 3: 0.
  - Bits [31:WIDHT] are always 0.
- read_data holds its value when read=0. Data is valid the cycle after the read strobe.
- Simultaneous read and write in one cycle: the write takes effect; read_data returns the pre-write register value.
- Reset asserted mid-operation: all pins float immediately (asynchronous); pending strobes are discarded.
- Strobes while reset is low are ignored.

Optional Feature:
- Macro GPIO_SYNC_EN.
- Defined:
  - pin_in comes through a two-flop synchronizer per pin, reset to 0.
  - An external pin change is visible to a read issued 2 cycles later; read_data then updates one edge after that read.
- Undefined:
  - pin_in = gpio directly (combinational into the read_data register).
  - A pin change is visible to a read strobe sampled on the very next edge.
- Register map, write semantics and reset values are identical in both builds.

Test Plan:
1. Reset behaviour (WIDHT=5): hold reset low, then release.
   - gpio all Z, read_data=0.
   - Reads at 0x4 -> 0x1F; at 0x8 -> 0x00.
2. Direction write: write 0x00000015; external drivers on pins 0,2,4 held 0.
   - dir=0x15; pins 1,3 driven with out=0.
   - Read 0x4 -> 0x15; read 0x0 -> 0x00.
3. Output write: write 0x8000001F.
   - out=0x1F; pins 1,3 drive 1; pins 0,2,4 stay Z.
   - Read 0x8 -> 0x1F; read 0x0 -> 0x0A.
4. Input sampling: bench drives pins 0 and 4 to 1, pin 2 to 0.
   - After the synchronizer latency, read 0x0 -> 0x1B.
5. Output clear and readback: write 0x80000000.
   - Pins 1,3 drop to 0; read 0x0 -> 0x11; read 0x4 -> 0x15 (unchanged).
6. Corner cases:
   - Same-cycle read 0x8 and write 0x80000003 -> read_data returns the old out value; a subsequent read -> 0x03.
   - Assert reset mid-sequence -> all pins Z at once; dir=0x1F.
